// File: rtl/array_cfg_fsm_pkg.sv
// Shared definitions for the array configuration sequencer.
// - state_t        : sequencer states
// - DIR_*          : direction indices, matching bit positions of the direction mask
// - dir_drow/dcol  : signed (row, col) offsets of each direction
package cfg_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COL_SHIFT,
    ST_COL_WAIT,
    ST_DIR_SEL,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_ROW_SHIFT,
    ST_ROW_WAIT,
    ST_KEY_WR,
    ST_KEY_WAIT,
    ST_COL_NEXT,
    ST_DONE
  } state_t;

  localparam logic [1:0] DIR_ARL = 2'd0;
  localparam logic [1:0] DIR_NE  = 2'd1;
  localparam logic [1:0] DIR_SE  = 2'd2;
  localparam logic [1:0] DIR_WW  = 2'd3;

  localparam logic signed [1:0] DROW_ARL = 2'sd0;
  localparam logic signed [1:0] DROW_NE  = -2'sd1;
  localparam logic signed [1:0] DROW_SE  = 2'sd1;
  localparam logic signed [1:0] DROW_WW  = 2'sd0;

  localparam logic signed [1:0] DCOL_ARL = 2'sd0;
  localparam logic signed [1:0] DCOL_NE  = 2'sd1;
  localparam logic signed [1:0] DCOL_SE  = 2'sd1;
  localparam logic signed [1:0] DCOL_WW  = -2'sd1;

  function automatic logic signed [1:0] dir_drow(input logic [1:0] dir);
    case (dir)
      DIR_NE:  return DROW_NE;
      DIR_SE:  return DROW_SE;
      DIR_WW:  return DROW_WW;
      default: return DROW_ARL;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dcol(input logic [1:0] dir);
    case (dir)
      DIR_NE:  return DCOL_NE;
      DIR_SE:  return DCOL_SE;
      DIR_WW:  return DCOL_WW;
      default: return DCOL_ARL;
    endcase
  endfunction

endpackage

// File: rtl/array_cfg_fsm_if.sv
// Frame-RAM read port and chip configuration shift port of the sequencer.
// master : sequencer side (drives read strobe/address and shift strobes)
// slave  : RAM / chip side (returns read data and chip-ready)
interface array_cfg_fsm_if #(
  parameter int NB_DATA = 12,
  parameter int NB_ROW  = 5,
  parameter int NB_COL  = 5
);
  logic               o_ram_read;
  logic [NB_ROW-1:0]  o_ram_row;
  logic [NB_COL-1:0]  o_ram_col;
  logic [NB_DATA-1:0] i_ram_data;
  logic               i_chip_ready;
  logic               o_row_reg_data;
  logic               o_row_reg_write;
  logic               o_col_reg_data;
  logic               o_col_reg_write;
  logic               o_key_wren;

  modport master (
    output o_ram_read, o_ram_row, o_ram_col,
    input  i_ram_data, i_chip_ready,
    output o_row_reg_data, o_row_reg_write,
    output o_col_reg_data, o_col_reg_write, o_key_wren
  );

  modport slave (
    input  o_ram_read, o_ram_row, o_ram_col,
    output i_ram_data, i_chip_ready,
    input  o_row_reg_data, o_row_reg_write,
    input  o_col_reg_data, o_col_reg_write, o_key_wren
  );
endinterface

// File: rtl/array_cfg_fsm_addr_gen.sv
// Neighbour target address for (row, col, dir), with in-bounds flag.
// Ports: row/col/dir in; tgt_row/tgt_col/in_bounds out (purely combinational).
module cfg_addr_gen
  import cfg_fsm_pkg::*;
#(
  parameter int N_ROWS = 24,
  parameter int N_COLS = 24,
  parameter int NB_ROW = 5,
  parameter int NB_COL = 5
) (
  input  logic [NB_ROW-1:0] row,
  input  logic [NB_COL-1:0] col,
  input  logic [1:0]        dir,
  output logic [NB_ROW-1:0] tgt_row,
  output logic [NB_COL-1:0] tgt_col,
  output logic              in_bounds
);
  // Two extra bits hold both the sign and a possible carry past the array edge.
  localparam logic signed [NB_ROW+1:0] ROW_MAX = (NB_ROW+2)'(N_ROWS - 1);
  localparam logic signed [NB_COL+1:0] COL_MAX = (NB_COL+2)'(N_COLS - 1);

  logic signed [1:0]        drow, dcol;
  logic signed [NB_ROW+1:0] r_s;
  logic signed [NB_COL+1:0] c_s;

  always_comb begin
    drow      = dir_drow(dir);
    dcol      = dir_dcol(dir);
    r_s       = $signed({2'b00, row}) + $signed({{NB_ROW{drow[1]}}, drow});
    c_s       = $signed({2'b00, col}) + $signed({{NB_COL{dcol[1]}}, dcol});
    in_bounds = !r_s[NB_ROW+1] && (r_s <= ROW_MAX) &&
                !c_s[NB_COL+1] && (c_s <= COL_MAX);
    tgt_row   = r_s[NB_ROW-1:0];
    tgt_col   = c_s[NB_COL-1:0];
  end
endmodule

// File: rtl/array_cfg_fsm.sv
// Column-by-column configuration sequencer: reads neighbour pixels from the
// frame RAM, thresholds them and shifts row masks, column tokens and key
// strobes into the chip configuration registers.
// Ports: clk, rst (sync, active-low); i_go/i_abort control; i_dir_mask and
// i_umbral latched on start; bus = RAM read + chip shift port;
// o_busy, o_done, o_pix_count status.
//
// state      | meaning
// IDLE       | waiting for i_go
// COL_SHIFT  | shift column token when chip ready
// COL_WAIT   | wait for chip after column token
// DIR_SEL    | pick next enabled direction for this column
// RD_REQ     | issue RAM read (or zero bit if target off-array)
// RD_WAIT    | threshold RAM data
// ROW_SHIFT  | shift row bit when chip ready
// ROW_WAIT   | wait for chip, then next row or key write
// KEY_WR     | pulse key write when chip ready
// KEY_WAIT   | wait for chip, then next direction
// COL_NEXT   | next column or finish
// DONE       | one-cycle completion pulse
module array_cfg_fsm
  import cfg_fsm_pkg::*;
#(
  parameter int NB_DATA = 12,
  parameter int N_ROWS  = 24,
  parameter int N_COLS  = 24,
  parameter int NB_ROW  = $clog2(N_ROWS),
  parameter int NB_COL  = $clog2(N_COLS),
  parameter int NB_CNT  = $clog2(4*N_ROWS*N_COLS+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_go,
  input  logic               i_abort,
  input  logic [3:0]         i_dir_mask,
  input  logic [NB_DATA-1:0] i_umbral,
  array_cfg_fsm_if.master    bus,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_CNT-1:0]  o_pix_count
);
  state_t             state_q, state_d;
  logic [NB_COL-1:0]  col_q;
  logic [NB_ROW-1:0]  row_q;
  logic [2:0]         dir_q;      // value 4 means no direction left
  logic [3:0]         mask_q;
  logic [NB_DATA-1:0] umbral_q;
  logic               bit_q;
  logic [NB_CNT-1:0]  pix_q;

  logic [NB_ROW-1:0]  tgt_row;
  logic [NB_COL-1:0]  tgt_col;
  logic               in_bounds;
  logic [3:0]         dir_en;
  logic               dir_found;
  logic [2:0]         dir_next;
  logic               abort_hit;
  logic               col_wr, row_wr, key_wr, ram_rd;

  cfg_addr_gen #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .NB_ROW(NB_ROW), .NB_COL(NB_COL)
  ) u_addr_gen (
    .row(row_q), .col(col_q), .dir(dir_q[1:0]),
    .tgt_row(tgt_row), .tgt_col(tgt_col), .in_bounds(in_bounds)
  );

  always_comb begin
    state_d   = state_q;
    col_wr    = 1'b0;
    row_wr    = 1'b0;
    key_wr    = 1'b0;
    ram_rd    = 1'b0;
    dir_found = 1'b0;
    dir_next  = dir_q;
    // ARL only exists on odd columns.
    dir_en    = mask_q & {3'b111, col_q[0]};
    for (int d = 0; d < 4; d++) begin
      if (!dir_found && (3'(d) >= dir_q) && dir_en[d]) begin
        dir_found = 1'b1;
        dir_next  = 3'(d);
      end
    end

    case (state_q)
      ST_IDLE:      if (i_go) state_d = ST_COL_SHIFT;
      ST_COL_SHIFT: if (bus.i_chip_ready) begin
                      col_wr  = 1'b1;
                      state_d = ST_COL_WAIT;
                    end
      ST_COL_WAIT:  if (bus.i_chip_ready) state_d = ST_DIR_SEL;
      ST_DIR_SEL:   state_d = dir_found ? ST_RD_REQ : ST_COL_NEXT;
      ST_RD_REQ:    if (in_bounds) begin
                      ram_rd  = 1'b1;
                      state_d = ST_RD_WAIT;
                    end else begin
                      state_d = ST_ROW_SHIFT;
                    end
      ST_RD_WAIT:   state_d = ST_ROW_SHIFT;
      ST_ROW_SHIFT: if (bus.i_chip_ready) begin
                      row_wr  = 1'b1;
                      state_d = ST_ROW_WAIT;
                    end
      ST_ROW_WAIT:  if (bus.i_chip_ready) state_d = (row_q == '0) ? ST_KEY_WR : ST_RD_REQ;
      ST_KEY_WR:    if (bus.i_chip_ready) begin
                      key_wr  = 1'b1;
                      state_d = ST_KEY_WAIT;
                    end
      ST_KEY_WAIT:  if (bus.i_chip_ready) state_d = ST_DIR_SEL;
      ST_COL_NEXT:  state_d = (col_q == NB_COL'(N_COLS - 1)) ? ST_DONE : ST_COL_SHIFT;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Abort wins over every transition and suppresses any strobe this cycle.
    abort_hit = i_abort && (state_q != ST_IDLE);
    if (abort_hit) begin
      state_d = ST_IDLE;
      col_wr  = 1'b0;
      row_wr  = 1'b0;
      key_wr  = 1'b0;
      ram_rd  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      dir_q    <= '0;
      mask_q   <= '0;
      umbral_q <= '0;
      bit_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!abort_hit) begin
        case (state_q)
          ST_IDLE: if (i_go) begin
            mask_q   <= i_dir_mask;
            umbral_q <= i_umbral;
            col_q    <= '0;
            dir_q    <= {1'b0, DIR_ARL};
            pix_q    <= '0;
          end
          ST_DIR_SEL: begin
            dir_q <= dir_found ? dir_next : 3'd4;
            row_q <= NB_ROW'(N_ROWS - 1);
          end
          ST_RD_REQ:    if (!in_bounds) bit_q <= 1'b0;
          ST_RD_WAIT:   bit_q <= (bus.i_ram_data >= umbral_q);
          ST_ROW_SHIFT: if (row_wr) pix_q <= pix_q + NB_CNT'(bit_q);
          ST_ROW_WAIT:  if (bus.i_chip_ready && row_q != '0) row_q <= row_q - 1'b1;
          ST_KEY_WAIT:  if (bus.i_chip_ready) dir_q <= dir_q + 3'd1;
          ST_COL_NEXT:  if (col_q != NB_COL'(N_COLS - 1)) begin
            col_q <= col_q + 1'b1;
            dir_q <= {1'b0, DIR_ARL};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_ram_read      = ram_rd;
  assign bus.o_ram_row       = tgt_row;
  assign bus.o_ram_col       = tgt_col;
  assign bus.o_row_reg_write = row_wr;
  assign bus.o_row_reg_data  = row_wr & bit_q;
  assign bus.o_col_reg_write = col_wr;
  assign bus.o_col_reg_data  = col_wr & (col_q == '0);
  assign bus.o_key_wren      = key_wr;
  assign o_busy              = (state_q != ST_IDLE);
  assign o_done              = (state_q == ST_DONE);
  assign o_pix_count         = pix_q;

endmodule

// File: tb/tb_array_cfg_fsm.sv
module tb_array_cfg_fsm;
  localparam int NB_DATA = 12;
  localparam int N_ROWS  = 4;
  localparam int N_COLS  = 4;
  localparam int NB_ROW  = 2;
  localparam int NB_COL  = 2;
  localparam int NB_CNT  = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_go, i_abort;
  logic [3:0]         i_dir_mask;
  logic [NB_DATA-1:0] i_umbral;
  logic               o_busy, o_done;
  logic [NB_CNT-1:0]  o_pix_count;

  array_cfg_fsm_if #(.NB_DATA(NB_DATA), .NB_ROW(NB_ROW), .NB_COL(NB_COL)) bus ();

  array_cfg_fsm #(
    .NB_DATA(NB_DATA), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
    .NB_ROW(NB_ROW), .NB_COL(NB_COL), .NB_CNT(NB_CNT)
  ) dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_abort(i_abort),
    .i_dir_mask(i_dir_mask), .i_umbral(i_umbral), .bus(bus),
    .o_busy(o_busy), .o_done(o_done), .o_pix_count(o_pix_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: expected strobe events encoded as
  // 10000+colbit, 20000+row*100+col (RAM read), 30000+rowbit, 40000 (key).
  logic [NB_DATA-1:0] ram [N_ROWS][N_COLS];
  int exp_q[$];
  int exp_pix, exp_cyc;
  int checks = 0, errors = 0;

  int busy_cyc = 0, done_cnt = 0, row_cnt = 0, col_cnt = 0, key_cnt = 0, rd_cnt = 0;
  int strobe_cnt = 0;
  int stall_mode = 0, rdy_seen = 0, rdy_left = 0;
  int mon_n, mon_code, mon_exp;
  logic               ram_rd_s;
  logic [NB_ROW-1:0]  ram_row_s;
  logic [NB_COL-1:0]  ram_col_s;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_model(input logic [3:0] m, input int u);
    int drow[4];
    int dcol[4];
    int tr, tc, b;
    drow = '{0, -1, 1, 0};
    dcol = '{0, 1, 1, -1};
    exp_q.delete();
    exp_pix = 0;
    exp_cyc = 1;
    for (int c = 0; c < N_COLS; c++) begin
      exp_q.push_back(10000 + ((c == 0) ? 1 : 0));
      exp_cyc += 2;
      for (int d = 0; d < 4; d++) begin
        if (m[d] && (d != 0 || (c % 2) == 1)) begin
          exp_cyc += 3;
          for (int r = N_ROWS - 1; r >= 0; r--) begin
            tr = r + drow[d];
            tc = c + dcol[d];
            if (tr >= 0 && tr < N_ROWS && tc >= 0 && tc < N_COLS) begin
              exp_q.push_back(20000 + tr * 100 + tc);
              b = (int'(ram[tr][tc]) >= u) ? 1 : 0;
              exp_cyc += 4;
            end else begin
              b = 0;
              exp_cyc += 3;
            end
            exp_q.push_back(30000 + b);
            exp_pix += b;
          end
          exp_q.push_back(40000);
        end
      end
      exp_cyc += 2;
    end
  endtask

  task automatic fill_ram(input int v, input int rnd);
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++)
        ram[r][c] = rnd ? NB_DATA'($urandom_range(0, 255)) : NB_DATA'(v);
  endtask

  // Monitor / compare process
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      if (o_busy) busy_cyc++;
      if (o_done) done_cnt++;
      mon_n = int'(bus.o_ram_read) + int'(bus.o_row_reg_write) +
              int'(bus.o_col_reg_write) + int'(bus.o_key_wren);
      if (mon_n > 0) begin
        if (mon_n > 1) check("one_strobe", mon_n, 1);
        mon_code = 0;
        if (bus.o_col_reg_write) begin
          mon_code = 10000 + int'(bus.o_col_reg_data); col_cnt++;
        end else if (bus.o_ram_read) begin
          mon_code = 20000 + int'(bus.o_ram_row) * 100 + int'(bus.o_ram_col); rd_cnt++;
        end else if (bus.o_row_reg_write) begin
          mon_code = 30000 + int'(bus.o_row_reg_data); row_cnt++;
        end else begin
          mon_code = 40000; key_cnt++;
        end
        if (!bus.o_ram_read) begin
          strobe_cnt++;
          check("strobe_while_ready", int'(bus.i_chip_ready), 1);
        end
        if (exp_q.size() == 0) check("unexpected_event", mon_code, -1);
        else begin
          mon_exp = exp_q.pop_front();
          check("event", mon_code, mon_exp);
        end
      end
    end
  end

  // RAM: data valid one cycle after the read strobe, garbage otherwise
  initial begin
    bus.i_ram_data = '0;
    forever begin
      @(negedge clk);
      ram_rd_s  = bus.o_ram_read;
      ram_row_s = bus.o_ram_row;
      ram_col_s = bus.o_ram_col;
      @(posedge clk); #1;
      bus.i_ram_data = ram_rd_s ? ram[ram_row_s][ram_col_s] : NB_DATA'($urandom);
    end
  end

  // Chip ready: 0 = always high, 1 = low 5 cycles after each strobe, 2 = random
  initial begin
    bus.i_chip_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (stall_mode)
        1: begin
          if (strobe_cnt != rdy_seen) begin
            rdy_seen = strobe_cnt;
            rdy_left = 5;
          end
          if (rdy_left > 0) begin
            bus.i_chip_ready = 1'b0;
            rdy_left--;
          end else bus.i_chip_ready = 1'b1;
        end
        2: begin
          rdy_seen = strobe_cnt;
          bus.i_chip_ready = ($urandom_range(0, 3) != 0);
        end
        default: begin
          rdy_seen = strobe_cnt;
          rdy_left = 0;
          bus.i_chip_ready = 1'b1;
        end
      endcase
    end
  end

  task automatic pulse_go(input logic [3:0] m, input int u);
    i_dir_mask = m;
    i_umbral   = NB_DATA'(u);
    i_go       = 1'b1;
    @(posedge clk); #1;
    i_go       = 1'b0;
    i_dir_mask = 4'($urandom);
    i_umbral   = NB_DATA'($urandom);
    check("busy_rise", int'(o_busy), 1);
    check("pix_clear", int'(o_pix_count), 0);
  endtask

  task automatic do_run(input logic [3:0] m, input int u, input int mode, input int chk_cyc);
    int b_busy, b_done, guard;
    build_model(m, u);
    stall_mode = mode;
    b_busy = busy_cyc;
    b_done = done_cnt;
    pulse_go(m, u);
    guard = 0;
    while (done_cnt == b_done && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_timeout", int'(guard < 5000), 1);
    check("pix_count", int'(o_pix_count), exp_pix);
    check("queue_drained", exp_q.size(), 0);
    if (chk_cyc != 0) check("busy_cycles", busy_cyc - b_busy, exp_cyc);
    repeat (3) @(posedge clk); #1;
    check("done_once", done_cnt - b_done, 1);
    check("idle_after", int'(o_busy), 0);
  endtask

  int b_row, b_col, b_key, b_rd, b_done2, guard2, snap;

  initial begin
    rst = 1'b0; i_go = 1'b0; i_abort = 1'b0; i_dir_mask = '0; i_umbral = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_pix", int'(o_pix_count), 0);
    check("rst_addr", int'(bus.o_ram_row) * 100 + int'(bus.o_ram_col), 0);
    check("rst_strobes", int'({bus.o_ram_read, bus.o_row_reg_write, bus.o_row_reg_data,
                               bus.o_col_reg_write, bus.o_col_reg_data, bus.o_key_wren}), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Full mask, all pixels above threshold
    fill_ram(200, 0);
    b_row = row_cnt; b_key = key_cnt; b_col = col_cnt;
    do_run(4'hf, 100, 0, 1);
    check("model_pix_full", exp_pix, 38);
    check("model_cyc_full", exp_cyc, 265);
    check("row_bits_full", row_cnt - b_row, 56);
    check("keys_full", key_cnt - b_key, 14);
    check("cols_full", col_cnt - b_col, 4);

    // Threshold boundary
    fill_ram(99, 0);
    do_run(4'hf, 100, 0, 1);
    check("below_umbral_pix", int'(o_pix_count), 0);
    fill_ram(100, 0);
    do_run(4'hf, 100, 0, 1);
    check("equal_umbral_pix", int'(o_pix_count), 38);

    // Empty mask: column tokens only
    b_col = col_cnt; b_rd = rd_cnt; b_row = row_cnt; b_key = key_cnt;
    do_run(4'h0, 100, 0, 1);
    check("model_cyc_empty", exp_cyc, 17);
    check("cols_empty", col_cnt - b_col, 4);
    check("reads_empty", rd_cnt - b_rd, 0);
    check("rows_keys_empty", (row_cnt - b_row) + (key_cnt - b_key), 0);

    // Chip stalls after each strobe
    fill_ram(0, 1);
    do_run(4'hf, 128, 1, 0);

    // Single edge directions: out-of-bounds targets read nothing
    fill_ram(0, 1);
    do_run(4'b1110, $urandom_range(60, 200), 0, 1);

    // Randomized runs
    for (int k = 0; k < 6; k++) begin
      fill_ram(0, 1);
      do_run(4'($urandom_range(0, 15)), $urandom_range(40, 220), (k % 2) * 2, (k % 2 == 0) ? 1 : 0);
    end

    // Abort while waiting for the chip after the first row bit
    fill_ram(200, 0);
    build_model(4'hf, 100);
    stall_mode = 1;
    b_row = row_cnt; b_done2 = done_cnt;
    pulse_go(4'hf, 100);
    guard2 = 0;
    while (row_cnt == b_row && guard2 < 2000) begin
      @(posedge clk); #1;
      guard2++;
    end
    check("abort_wait_timeout", int'(guard2 < 2000), 1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    exp_q.delete();
    check("abort_idle", int'(o_busy), 0);
    check("abort_pix_hold", int'(o_pix_count), 1);
    repeat (8) @(posedge clk); #1;
    check("abort_no_done", done_cnt - b_done2, 0);
    do_run(4'hf, 100, 1, 0);
    check("restart_pix", int'(o_pix_count), 38);

    // Reset in the middle of a run
    stall_mode = 0;
    fill_ram(0, 1);
    build_model(4'hf, 100);
    pulse_go(4'hf, 100);
    repeat (30) @(posedge clk); #1;
    snap = int'(o_busy);
    check("midrun_busy", snap, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mrst_busy", int'(o_busy), 0);
    check("mrst_done", int'(o_done), 0);
    check("mrst_pix", int'(o_pix_count), 0);
    check("mrst_addr", int'(bus.o_ram_row) * 100 + int'(bus.o_ram_col), 0);
    check("mrst_strobes", int'({bus.o_ram_read, bus.o_row_reg_write,
                                bus.o_col_reg_write, bus.o_key_wren}), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_run(4'h0, 100, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/array_cfg_fsm.md
# array_cfg_fsm

Parametrised successor of the single-array configuration FSM. It walks an N_ROWS × N_COLS pixel image held in RAM column by column. For each column it evaluates up to four neighbour directions against a latched threshold and shifts the resulting row masks, column token and key strobes into the sensor chip's configuration registers. It sits between the frame RAM and the chip configuration shift interface, and owns its own row/column address counters.

## Interface
- NB_DATA, 12, pixel/threshold width
- N_ROWS, 24, array rows (≥2)
- N_COLS, 24, array columns (≥2)
- NB_ROW, $clog2(N_ROWS), row address width
- NB_COL, $clog2(N_COLS), column address width
- NB_CNT, $clog2(4*N_ROWS*N_COLS+1), valid-pixel counter width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- i_go  in  1  start pulse; ignored while o_busy
- i_abort  in  1  abandon sequence, return to IDLE
- i_dir_mask  in  4  enabled directions {WW,SE,NE,ARL}; latched on accepted i_go
- i_umbral  in  NB_DATA  threshold; latched on accepted i_go
- i_chip_ready  in  1  chip shift interface idle
- i_ram_data  in  NB_DATA  RAM read data, valid 1 cycle after o_ram_read
- o_ram_read  out  1  RAM read strobe
- o_ram_row  out  NB_ROW  RAM row address
- o_ram_col  out  NB_COL  RAM column address
- o_row_reg_data / o_row_reg_write  out  1 / 1  row shift bit / strobe
- o_col_reg_data / o_col_reg_write  out  1 / 1  column shift bit / strobe
- o_key_wren  out  1  latch shifted row mask into chip key register
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse on normal completion
- o_pix_count  out  NB_CNT  number of '1' row bits shifted in last/current run

## Operation
- States: IDLE, COL_SHIFT, COL_WAIT, DIR_SEL, RD_REQ, RD_WAIT, ROW_SHIFT, ROW_WAIT, KEY_WR, KEY_WAIT, COL_NEXT, DONE.
- IDLE: i_go → COL_SHIFT; latch mask and umbral; col=0, dir=ARL, o_pix_count cleared.
- COL_SHIFT: waits i_chip_ready=1, then pulses o_col_reg_write with o_col_reg_data=(col==0) and moves to COL_WAIT. COL_WAIT exits on i_chip_ready=1 → DIR_SEL.
- DIR_SEL: advances dir to the first enabled direction ≥ current. ARL is enabled only on odd columns. If none remain → COL_NEXT; otherwise row=N_ROWS-1 → RD_REQ.
- Direction offsets (Δrow, Δcol): ARL (0,0), NE (−1,+1), SE (+1,+1), WW (0,−1). Target = (row+Δrow, col+Δcol), signed compare against [0,N_ROWS-1]/[0,N_COLS-1].
- RD_REQ: in-bounds → o_ram_read=1 with target address, → RD_WAIT. Out-of-bounds → no read, bit=0, → ROW_SHIFT.
- RD_WAIT: bit = (i_ram_data ≥ umbral), unsigned compare; → ROW_SHIFT.
- ROW_SHIFT: waits i_chip_ready=1, then pulses o_row_reg_write with bit; o_pix_count += bit; → ROW_WAIT. ROW_WAIT exits on i_chip_ready=1: row==0 → KEY_WR, else row−1 → RD_REQ.
- KEY_WR: waits i_chip_ready=1, then pulses o_key_wren; → KEY_WAIT. On i_chip_ready=1: dir+1 → DIR_SEL.
- COL_NEXT: col==N_COLS-1 → DONE; else col+1, dir=ARL → COL_SHIFT.
- DONE: o_done=1 for one cycle → IDLE.
- i_dir_mask=0: only column tokens are shifted; no RAM reads, no row/key strobes.
- i_abort (any non-IDLE state, priority over all transitions) → IDLE next cycle. Strobes drop, no o_done, o_pix_count holds.
- i_go together with i_abort in IDLE: i_go accepted.

## Timing
- Reset (rst=0 at edge): state IDLE, all strobes/data 0, o_busy=0, o_done=0, addresses 0, o_pix_count 0, latched mask/umbral 0.
- All outputs registered or decoded from registered state; no combinational path from i_chip_ready to strobes beyond the state decode.
- Strobes are exactly one cycle wide. Each WAIT state lasts ≥1 cycle and checks i_chip_ready from the cycle after the strobe.
- With i_chip_ready tied high: in-bounds row bit = 4 cycles, out-of-bounds = 3, key = 2, column token = 2, DIR_SEL and COL_NEXT 1 each. o_busy rises the cycle after i_go.
- o_ram_row/o_ram_col are stable from RD_REQ through RD_WAIT.

## Structure
- Package cfg_fsm_pkg: state enum localparams, direction indices (DIR_ARL=0…DIR_WW=3), Δrow/Δcol constants.
- Sub-module cfg_addr_gen: combinational target-address and in-bounds computation from (row, col, dir). Row/column counters and FSM stay in array_cfg_fsm.

## Test plan
- N_ROWS=N_COLS=4, mask=4'b1111, umbral=100, all RAM=200, ready high → per column 12/16 row bits plus 3/4 key pulses (even/odd), o_pix_count matches in-bounds count, o_done once.
- All RAM=99, umbral=100 → every o_row_reg_data=0, o_pix_count=0; RAM=100 → all in-bounds bits 1 (≥ boundary).
- mask=4'b0000 → exactly 4 o_col_reg_write pulses, data 1,0,0,0; no o_ram_read; o_done.
- i_chip_ready held low 5 cycles after each strobe → no second strobe until ready returns; sequence identical to ready-high run.
- Col 0 / row 0 with NE, WW, SE → out-of-bounds targets produce bit 0 with no o_ram_read.
- i_abort mid-ROW_WAIT → IDLE next cycle, no o_done; new i_go restarts at col 0 with o_pix_count cleared.
- rst=0 mid-run → all outputs at reset values on the next edge.
